// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO: pops words, absorbs the 1-cycle
// read latency in a 3-entry skid buffer and presents them as a valid/ready stream.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] beat_count
);

  localparam int DEPTH = 3;

  typedef logic [1:0] ptr_t;

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [WIDTH-1:0] buf_d [DEPTH];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             infl_q, infl_d;
  logic [CNT_W-1:0] beat_count_q, beat_count_d;

  logic             capture;
  logic             pop;
  logic [2:0]       credit_used;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check counts the word already in flight, so a read is only issued
  // when a buffer slot is guaranteed for it; m_ready never enters this path.
  always_comb begin
    credit_used = {1'b0, occ_q} + {2'b00, infl_q};
    fifo_rd_en  = !rst && !flush && !fifo_empty && (credit_used <= 3'd2);
  end

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf_q[head_q];
  assign beat_count = beat_count_q;
  assign capture    = infl_q && !flush;
  assign pop        = m_valid && m_ready;

  always_comb begin
    // NOTE: every _d signal gets a default first so no path leaves it unassigned (no latches).
    buf_d        = buf_q;
    head_d       = head_q;
    tail_d       = tail_q;
    occ_d        = occ_q;
    infl_d       = fifo_rd_en;
    beat_count_d = beat_count_q + {{(CNT_W-1){1'b0}}, pop};

    if (flush) begin
      head_d = 2'd0;
      tail_d = 2'd0;
      occ_d  = 2'd0;
      infl_d = 1'b0;
    end else begin
      if (capture) begin
        buf_d[tail_q] = fifo_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      case ({capture, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the small buffer is reset too, so m_data reads zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      head_q       <= 2'd0;
      tail_q       <= 2'd0;
      occ_q        <= 2'd0;
      infl_q       <= 1'b0;
      beat_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      infl_q       <= infl_d;
      beat_count_q <= beat_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: FIFO model, word-level reference
// model checked every cycle, plus directed and randomized scenario tasks.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        force_empty = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd_en, m_valid;
  logic [7:0]  fifo_data = 8'h00;
  logic [7:0]  m_data;
  logic [15:0] beat_count;
  logic        fifo_rd_en4, m_valid4;
  logic [7:0]  m_data4;
  logic [3:0]  beat_count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .beat_count(beat_count)
  );

  fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en4),
    .fifo_data(fifo_data), .flush(flush), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .beat_count(beat_count4)
  );

  // FIFO model: data appears the cycle after an accepted read.
  logic [7:0] fq[$];
  int         f_level = 0;
  logic       rd_pend = 1'b0;

  assign fifo_empty = (f_level == 0) || force_empty;

  always @(negedge clk) rd_pend = fifo_rd_en && !fifo_empty;

  always @(posedge clk) begin
    if (rd_pend && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
      f_level = f_level - 1;
    end
  end

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    f_level = f_level + 1;
  endtask

  // Reference model: list of words held by the reader, arrival flag, beat count.
  logic [7:0]  mq[$];
  logic        m_arr = 1'b0;
  logic [15:0] m_cnt = 16'h0000;
  logic        mon_en = 1'b0;
  logic [7:0]  out_log[$];
  logic        exp_rd, exp_v, hs;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_v  = (mq.size() != 0);
      exp_rd = !rst && !flush && !fifo_empty && ((mq.size() + (m_arr ? 1 : 0)) <= 2);
      tests++;
      if (fifo_rd_en !== exp_rd) begin
        fails++;
        $display("FAIL mon_rd_en t=%0t got %b want %b", $time, fifo_rd_en, exp_rd);
      end
      tests++;
      if (fifo_rd_en4 !== exp_rd) begin
        fails++;
        $display("FAIL mon_rd_en4 t=%0t got %b want %b", $time, fifo_rd_en4, exp_rd);
      end
      tests++;
      if (m_valid !== exp_v || m_valid4 !== exp_v) begin
        fails++;
        $display("FAIL mon_valid t=%0t got %b/%b want %b", $time, m_valid, m_valid4, exp_v);
      end
      if (exp_v) begin
        tests++;
        if (m_data !== mq[0] || m_data4 !== mq[0]) begin
          fails++;
          $display("FAIL mon_data t=%0t got %h/%h want %h", $time, m_data, m_data4, mq[0]);
        end
      end
      tests++;
      if (beat_count !== m_cnt || beat_count4 !== m_cnt[3:0]) begin
        fails++;
        $display("FAIL mon_count t=%0t got %h/%h want %h", $time, beat_count, beat_count4, m_cnt);
      end
      if (m_valid && m_ready) out_log.push_back(m_data);

      hs = exp_v && m_ready;
      if (rst) begin
        mq.delete();
        m_cnt = 16'h0000;
        m_arr = 1'b0;
      end else if (flush) begin
        if (hs) m_cnt = m_cnt + 16'd1;
        mq.delete();
        m_arr = 1'b0;
      end else begin
        if (hs) begin
          void'(mq.pop_front());
          m_cnt = m_cnt + 16'd1;
        end
        if (m_arr) mq.push_back(fifo_data);
        m_arr = fifo_rd_en && !fifo_empty;
        tests++;
        if (mq.size() > 3) begin
          fails++;
          $display("FAIL mon_occ t=%0t got %0d want <=3", $time, mq.size());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int c = 0;
    while (out_log.size() < n && c < budget) begin
      step();
      c++;
    end
    tests++;
    if (out_log.size() < n) begin
      fails++;
      $display("FAIL %s_timeout got %0d words want %0d", name, out_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
    step();
    step();
    tests++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 ||
        beat_count !== 16'h0 || beat_count4 !== 4'h0) begin
      fails++;
      $display("FAIL reset_state got rd=%b v=%b d=%h cnt=%h want 0 0 00 0000",
               fifo_rd_en, m_valid, m_data, beat_count);
    end
    mon_en = 1'b1;
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    int first_rd = -1, last_rd = -1, n_rd = 0, first_v = -1, last_v = -1;
    logic [7:0] dat[$];
    out_log.delete();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    #1;
    for (int c = 0; c < 20; c++) begin
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        n_rd++;
      end
      if (m_valid && m_ready) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        dat.push_back(m_data);
      end
      step();
    end
    tests++;
    if (n_rd != 8 || last_rd - first_rd != 7) begin
      fails++;
      $display("FAIL stream_reads got %0d reads span %0d want 8 span 7", n_rd, last_rd - first_rd);
    end
    tests++;
    if (first_v != first_rd + 2 || last_v - first_v != 7) begin
      fails++;
      $display("FAIL stream_latency got first_v=%0d span %0d want %0d span 7",
               first_v, last_v - first_v, first_rd + 2);
    end
    tests++;
    if (dat.size() != 8) begin
      fails++;
      $display("FAIL stream_count_words got %0d want 8", dat.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (dat[i] !== 8'(i + 1)) begin
          fails++;
          $display("FAIL stream_data[%0d] got %h want %h", i, dat[i], 8'(i + 1));
        end
      end
    end
    tests++;
    if (beat_count !== 16'd8) begin
      fails++;
      $display("FAIL stream_beat_count got %0d want 8", beat_count);
    end
  endtask

  task automatic test_backpressure();
    int n_rd = 0;
    out_log.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    #1;
    for (int c = 0; c < 10; c++) begin
      if (fifo_rd_en) n_rd++;
      if (m_valid) begin
        tests++;
        if (m_data !== 8'h10) begin
          fails++;
          $display("FAIL bp_hold cycle %0d got %h want 10", c, m_data);
        end
      end
      step();
    end
    tests++;
    if (n_rd != 3) begin
      fails++;
      $display("FAIL bp_reads got %0d want 3", n_rd);
    end
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_valid got %b want 1", m_valid);
    end
    m_ready = 1'b1;
    wait_out(6, 40, "bp");
    for (int i = 0; i < 6 && i < out_log.size(); i++) begin
      tests++;
      if (out_log[i] !== 8'h10 + 8'(i)) begin
        fails++;
        $display("FAIL bp_data[%0d] got %h want %h", i, out_log[i], 8'h10 + 8'(i));
      end
    end
    step();
    tests++;
    if (beat_count !== 16'd14) begin
      fails++;
      $display("FAIL bp_beat_count got %0d want 14", beat_count);
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] words[64];
    int c = 0;
    out_log.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      words[i] = 8'($urandom);
      push(words[i]);
    end
    while (out_log.size() < 64 && c < 1000) begin
      force_empty = ~force_empty;
      m_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    force_empty = 1'b0;
    m_ready = 1'b1;
    step();
    tests++;
    if (out_log.size() != 64) begin
      fails++;
      $display("FAIL bubbles_count got %0d want 64", out_log.size());
    end
    for (int i = 0; i < 64 && i < out_log.size(); i++) begin
      tests++;
      if (out_log[i] !== words[i]) begin
        fails++;
        $display("FAIL bubbles_data[%0d] got %h want %h", i, out_log[i], words[i]);
      end
    end
    tests++;
    if (beat_count !== 16'd78) begin
      fails++;
      $display("FAIL bubbles_beat_count got %0d want 78", beat_count);
    end
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    out_log.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    #1;
    step();
    step();
    step();
    cnt_before = m_cnt;
    tests++;
    if (m_valid !== 1'b1 || m_data !== 8'hA0 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL flush_setup got v=%b d=%h rd=%b want 1 a0 0", m_valid, m_data, fifo_rd_en);
    end
    flush = 1'b1;
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL flush_rd got %b want 0", fifo_rd_en);
    end
    step();
    flush = 1'b0;
    tests++;
    if (m_valid !== 1'b0 || beat_count !== cnt_before) begin
      fails++;
      $display("FAIL flush_after got v=%b cnt=%0d want 0 %0d", m_valid, beat_count, cnt_before);
    end
    m_ready = 1'b1;
    wait_out(3, 30, "flush");
    for (int i = 0; i < 3 && i < out_log.size(); i++) begin
      tests++;
      if (out_log[i] !== 8'hA3 + 8'(i)) begin
        fails++;
        $display("FAIL flush_data[%0d] got %h want %h", i, out_log[i], 8'hA3 + 8'(i));
      end
    end
    // Flush while the FIFO has data and credit is free must still block the read.
    push(8'hB0);
    push(8'hB1);
    flush = 1'b1;
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL flush_gate_rd got %b want 0", fifo_rd_en);
    end
    step();
    flush = 1'b0;
    wait_out(5, 30, "flush_b");
    for (int i = 3; i < 5 && i < out_log.size(); i++) begin
      tests++;
      if (out_log[i] !== 8'hB0 + 8'(i - 3)) begin
        fails++;
        $display("FAIL flush_b_data[%0d] got %h want %h", i, out_log[i], 8'hB0 + 8'(i - 3));
      end
    end
  endtask

  task automatic test_random_flush();
    int c = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && f_level < 8) push(8'($urandom));
      m_ready     = 1'($urandom_range(0, 1));
      force_empty = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;
    force_empty = 1'b0;
    m_ready = 1'b1;
    while ((f_level != 0 || mq.size() != 0 || m_arr) && c < 100) begin
      step();
      c++;
    end
    tests++;
    if (f_level != 0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL rand_drain got level=%0d v=%b want 0 0", f_level, m_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_log.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    #1;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_rd got %b want 0", fifo_rd_en);
    end
    step();
    tests++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || beat_count !== 16'h0 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_state got v=%b d=%h cnt=%h rd=%b want 0 00 0000 0",
               m_valid, m_data, beat_count, fifo_rd_en);
    end
    rst = 1'b0;
    m_ready = 1'b1;
    wait_out(3, 30, "rstmid");
    for (int i = 0; i < 3 && i < out_log.size(); i++) begin
      tests++;
      if (out_log[i] !== 8'hC3 + 8'(i)) begin
        fails++;
        $display("FAIL rstmid_data[%0d] got %h want %h", i, out_log[i], 8'hC3 + 8'(i));
      end
    end
    step();
    tests++;
    if (beat_count !== 16'd3) begin
      fails++;
      $display("FAIL rstmid_beat_count got %0d want 3", beat_count);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_log.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
    wait_out(17, 60, "wrap");
    tests++;
    if (beat_count4 !== 4'h1 || beat_count !== 16'd17) begin
      fails++;
      $display("FAIL wrap_count got %h/%0d want 1/17", beat_count4, beat_count);
    end
    for (int i = 0; i < 17 && i < out_log.size(); i++) begin
      tests++;
      if (out_log[i] !== 8'h40 + 8'(i)) begin
        fails++;
        $display("FAIL wrap_data[%0d] got %h want %h", i, out_log[i], 8'h40 + 8'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_random_flush();
    test_reset_mid();
    test_wrap();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side adapter for the team's synchronous FIFO.
- Pops words from the FIFO read port, absorbs the FIFO's 1-cycle read latency, and presents them on a valid/ready stream master interface.
- Has a small internal skid buffer so the stream runs at one beat per cycle.
- Sits between the FIFO and any downstream consumer, for example a serializer or a DMA write port.

Parameters:
WIDTH, 8, data word width; must match the FIFO's WIDTH.
CNT_W, 16, width of the delivered-beat counter.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  FIFO read request; one pop per cycle asserted.
fifo_data  input  WIDTH  FIFO read data; valid the cycle after an accepted fifo_rd_en.
flush  input  1  synchronous discard of all buffered and in-flight words.
m_valid  output  1  stream data valid.
m_ready  input  1  downstream ready.
m_data  output  WIDTH  stream data.
beat_count  output  CNT_W  number of words delivered (m_valid && m_ready), wrapping.

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is synchronous and active-high.
- Reset values:
  - m_valid=0, m_data=0, beat_count=0.
  - Buffer occupancy occ=0, in-flight flag infl=0.
  - fifo_rd_en=0 while rst is high.
- Skid buffer:
  - 3-entry circular buffer with head/tail pointers that wrap 2->0.
  - occ ranges 0..3.
- Read issue (combinational from registers and FIFO flag only):
  - fifo_rd_en = !rst && !flush && !fifo_empty && (occ + infl <= 2).
  - m_ready must never combinationally affect fifo_rd_en.
- In-flight tracking: infl <= fifo_rd_en, registered every cycle.
- Capture:
  - When infl=1 and flush=0, fifo_data is written at the tail in that cycle.
  - That write increments occ.
  - The credit rule guarantees no overflow; the bench asserts occ never exceeds 3.
- Output:
  - m_valid = (occ != 0). m_data = buffer[head].
  - m_data holds stable while m_valid && !m_ready.
  - A pop (m_valid && m_ready) advances head and decrements occ.
- Simultaneous capture and pop in one cycle: occ is unchanged, both pointers advance.
- Throughput:
  - With the FIFO never empty and m_ready held high, one beat per cycle in steady state.
  - First m_valid rises 2 cycles after the first fifo_rd_en: rd at cycle N, capture at the N+1 clock edge, m_valid high in cycle N+2.
- Backpressure:
  - With m_ready low, reads stop once occ + infl = 3.
  - No words are lost or duplicated.
- FIFO empty:
  - No read is issued. Existing buffered words still drain normally.
  - A read accepted before the FIFO went empty still completes.
- Flush:
  - Takes effect in the same cycle: fifo_rd_en=0 that cycle.
  - Any fifo_data arriving that cycle (infl=1) is discarded.
  - Next cycle: occ=0, infl=0, pointers reset to 0, m_valid=0.
  - A handshake in the flush cycle is still counted. beat_count is not cleared by flush.
- beat_count:
  - Increments by 1 on each m_valid && m_ready.
  - Wraps modulo 2^CNT_W with no saturation.
- Reset mid-operation: buffered and in-flight words are dropped and all state returns to the reset values on the next clock edge.
- Ordering: words leave in exact FIFO pop order.

Test Plan:
- Stream: FIFO preloaded 0x01..0x08, m_ready=1 -> fifo_rd_en high for 8 consecutive cycles; m_data 0x01..0x08 on 8 consecutive cycles starting 2 cycles after the first read; beat_count=8.
- Backpressure: preload 0x10..0x15, m_ready=0 for 10 cycles then 1 -> exactly 3 reads issued while stalled; m_data=0x10 held stable; 0x10..0x15 then delivered in order; beat_count=6.
- Bubbles: alternate fifo_empty 0/1 each cycle with m_ready toggling in a pseudo-random pattern over 64 words -> output equals input order, no duplicates, occ never exceeds 3.
- Flush: buffer holds 0xA0,0xA1 with 0xA2 in flight, assert flush 1 cycle -> 0xA2 discarded; m_valid=0 next cycle; the next delivered word is the next FIFO word, 0xA3; beat_count unchanged.
- Counter wrap: CNT_W=4, deliver 17 words -> beat_count reads 0x1 after the 17th beat.
- Reset mid-stream: assert rst while occ=2 and infl=1 -> next cycle m_valid=0, m_data=0, beat_count=0, fifo_rd_en=0 while rst is high; normal operation resumes after rst drops.
